// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard unit for the 5-stage RV32I pipeline. It keeps a shadow copy of the
//   destination-register tags of the instructions in EX, MEM and WB. From these
//   tags it drives the EX-stage operand forwarding selects, the load-use /
//   RAW stall, and the branch-redirect flush.
//
// Parameters
//   ADDR_W  register-index width
//   FWD_EN  1: forward from MEM/WB and stall only on load-use
//           0: no forwarding, stall on any RAW hazard against EX or MEM
//
// Ports
//   clk_i              rising-edge clock
//   rst_i              asynchronous reset, active-high
//   id_valid_i         ID stage holds a real instruction
//   id_rs1_i/id_rs2_i  ID source registers
//   id_rd_i            ID destination register
//   id_regwrite_i      ID instruction writes rd
//   id_memread_i       ID instruction is a load
//   ex_branch_taken_i  EX resolved a taken branch/jump this cycle
//   fwd_a_sel_o        rs1 operand select: 00 RF, 01 WB, 10 MEM
//   fwd_b_sel_o        rs2 operand select: 00 RF, 01 WB, 10 MEM
//   stall_o            hold PC and IF/ID, bubble into ID/EX
//   flush_o            squash IF/ID and ID/EX
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int ADDR_W = 5,
    parameter int FWD_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs1_i,
    input  logic [ADDR_W-1:0] id_rs2_i,
    input  logic [ADDR_W-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              ex_branch_taken_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o,
    output logic              flush_o
);

    // EX stage tag plus the source registers the EX instruction reads
    logic              r_exVld;
    logic              r_exWe;
    logic              r_exLd;
    logic [ADDR_W-1:0] r_exRd;
    logic [ADDR_W-1:0] r_exRs1;
    logic [ADDR_W-1:0] r_exRs2;

    // MEM stage tag
    logic              r_memVld;
    logic              r_memWe;
    logic              r_memLd;
    logic [ADDR_W-1:0] r_memRd;

    // WB stage tag; the load flag is not needed past MEM
    logic              r_wbVld;
    logic              r_wbWe;
    logic [ADDR_W-1:0] r_wbRd;

    logic              w_exHazard;
    logic              w_accept;

    // A stage "writes r" only for a live, register-writing instruction whose
    // destination is r. x0 is hard-wired zero, so it never creates a hazard.
    function automatic logic tagWrites(input logic              vld,
                                       input logic              we,
                                       input logic [ADDR_W-1:0] rd,
                                       input logic [ADDR_W-1:0] r);
        return vld && we && (rd == r) && (r != '0);
    endfunction

    // Operand select for one EX source. A load sitting in MEM has no data yet,
    // so it is skipped here; the load-use stall keeps that case from arising.
    function automatic logic [1:0] fwdSel(input logic [ADDR_W-1:0] rs);
        if (tagWrites(r_memVld, r_memWe, r_memRd, rs) && !r_memLd) begin
            return 2'b10;
        end else if (tagWrites(r_wbVld, r_wbWe, r_wbRd, rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Forwarding selects come only from registered tags, so there is no
    // combinational path from any input to these outputs.
    always_comb begin
        fwd_a_sel_o = 2'b00;
        fwd_b_sel_o = 2'b00;
        if (FWD_EN != 0) begin
            fwd_a_sel_o = fwdSel(r_exRs1);
            fwd_b_sel_o = fwdSel(r_exRs2);
        end
    end

    // Hazard detection against the instruction in ID. With forwarding, only a
    // load in EX forces a stall (one cycle, after which WB forwards the data).
    // Without forwarding, any writer in EX or MEM stalls until it reaches WB,
    // where the register file is write-first. rs2 is compared even for
    // instructions that do not use it; that only costs an occasional bubble.
    always_comb begin
        w_exHazard = 1'b0;
        if (FWD_EN != 0) begin
            w_exHazard = r_exLd &&
                         (tagWrites(r_exVld, r_exWe, r_exRd, id_rs1_i) ||
                          tagWrites(r_exVld, r_exWe, r_exRd, id_rs2_i));
        end else begin
            w_exHazard = tagWrites(r_exVld,  r_exWe,  r_exRd,  id_rs1_i) ||
                         tagWrites(r_exVld,  r_exWe,  r_exRd,  id_rs2_i) ||
                         tagWrites(r_memVld, r_memWe, r_memRd, id_rs1_i) ||
                         tagWrites(r_memVld, r_memWe, r_memRd, id_rs2_i);
        end
    end

    // A redirect overrides a stall: the stalled instruction is squashed anyway.
    // Both controls are held low for the whole time reset is asserted.
    always_comb begin
        flush_o  = !rst_i && ex_branch_taken_i;
        stall_o  = !rst_i && id_valid_i && w_exHazard && !ex_branch_taken_i;
        w_accept = id_valid_i && !stall_o && !flush_o;
    end

    // Tag pipeline: advances every cycle. EX takes the ID instruction only when
    // it is really issued; stalls and flushes insert a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_exVld  <= 1'b0;
            r_exWe   <= 1'b0;
            r_exLd   <= 1'b0;
            r_exRd   <= '0;
            r_exRs1  <= '0;
            r_exRs2  <= '0;
            r_memVld <= 1'b0;
            r_memWe  <= 1'b0;
            r_memLd  <= 1'b0;
            r_memRd  <= '0;
            r_wbVld  <= 1'b0;
            r_wbWe   <= 1'b0;
            r_wbRd   <= '0;
        end else begin
            r_wbVld  <= r_memVld;
            r_wbWe   <= r_memWe;
            r_wbRd   <= r_memRd;
            r_memVld <= r_exVld;
            r_memWe  <= r_exWe;
            r_memLd  <= r_exLd;
            r_memRd  <= r_exRd;
            if (w_accept) begin
                r_exVld <= 1'b1;
                r_exWe  <= id_regwrite_i;
                r_exLd  <= id_memread_i;
                r_exRd  <= id_rd_i;
                r_exRs1 <= id_rs1_i;
                r_exRs2 <= id_rs2_i;
            end else begin
                r_exVld <= 1'b0;
                r_exWe  <= 1'b0;
                r_exLd  <= 1'b0;
                r_exRd  <= '0;
                r_exRs1 <= '0;
                r_exRs2 <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. Two instances share the ID-side inputs:
//   dutFwd uses forwarding, dutNoFwd runs with forwarding disabled. Each
//   scenario task drives a short instruction sequence and compares outputs
//   against hand-derived values at the falling clock edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       idValid;
    logic [4:0] idRs1;
    logic [4:0] idRs2;
    logic [4:0] idRd;
    logic       idRegWrite;
    logic       idMemRead;
    logic       branchTaken;

    logic [1:0] fwdA;
    logic [1:0] fwdB;
    logic       stall;
    logic       flush;
    logic [1:0] nfFwdA;
    logic [1:0] nfFwdB;
    logic       nfStall;
    logic       nfFlush;

    int vecCount  = 0;
    int missCount = 0;

    hazard_ctrl #(.ADDR_W(5), .FWD_EN(1)) dutFwd (
        .clk_i            (clk),
        .rst_i            (rst),
        .id_valid_i       (idValid),
        .id_rs1_i         (idRs1),
        .id_rs2_i         (idRs2),
        .id_rd_i          (idRd),
        .id_regwrite_i    (idRegWrite),
        .id_memread_i     (idMemRead),
        .ex_branch_taken_i(branchTaken),
        .fwd_a_sel_o      (fwdA),
        .fwd_b_sel_o      (fwdB),
        .stall_o          (stall),
        .flush_o          (flush)
    );

    hazard_ctrl #(.ADDR_W(5), .FWD_EN(0)) dutNoFwd (
        .clk_i            (clk),
        .rst_i            (rst),
        .id_valid_i       (idValid),
        .id_rs1_i         (idRs1),
        .id_rs2_i         (idRs2),
        .id_rd_i          (idRd),
        .id_regwrite_i    (idRegWrite),
        .id_memread_i     (idMemRead),
        .ex_branch_taken_i(branchTaken),
        .fwd_a_sel_o      (nfFwdA),
        .fwd_b_sel_o      (nfFwdB),
        .stall_o          (nfStall),
        .flush_o          (nfFlush)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Put one instruction into ID
    task automatic applyStimulus(input logic v, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic we, input logic ld);
        idValid    = v;
        idRs1      = rs1;
        idRs2      = rs2;
        idRd       = rd;
        idRegWrite = we;
        idMemRead  = ld;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Move to just after the next rising edge, then to the checking point
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic doReset();
        idle();
        branchTaken = 1'b0;
        rst = 1'b1;
        #12;
        rst = 1'b0;
        nextCycle();
    endtask

    // Outputs are forced quiet during reset even with hazard-looking inputs
    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1);
        branchTaken = 1'b1;
        #3;
        vecCount++;
        if (flush !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_flush got %b want 0", flush);
        end
        vecCount++;
        if (stall !== 1'b0 || fwdA !== 2'b00 || fwdB !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL reset_outs got stall=%b a=%b b=%b want 0/00/00", stall, fwdA, fwdB);
        end
        branchTaken = 1'b0;
        idle();
        #10;
        rst = 1'b0;
        nextCycle();
    endtask

    // add x5,x1,x2 ; add x6,x5,x3 -> EX result forwarded from MEM
    task automatic test_back_to_back();
        doReset();
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        sample();
        vecCount++;
        if (stall !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL b2b_first_stall got %b want 0", stall);
        end
        nextCycle();
        applyStimulus(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0);
        sample();
        vecCount++;
        if (stall !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL b2b_alu_stall got %b want 0", stall);
        end
        nextCycle();
        idle();
        sample();
        vecCount++;
        if (fwdA !== 2'b10 || fwdB !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL b2b_fwd got a=%b b=%b want a=10 b=00", fwdA, fwdB);
        end
    endtask

    // add x5 ; gap ; sub x7,x3,x5 -> WB forward; then MEM beats WB
    task automatic test_wb_and_priority();
        doReset();
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        nextCycle();
        idle();
        nextCycle();
        applyStimulus(1'b1, 5'd3, 5'd5, 5'd7, 1'b1, 1'b0);
        nextCycle();
        idle();
        sample();
        vecCount++;
        if (fwdA !== 2'b00 || fwdB !== 2'b01) begin
            missCount++;
            $display("[TB] FAIL wb_fwd got a=%b b=%b want a=00 b=01", fwdA, fwdB);
        end

        doReset();
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd3, 5'd5, 5'd7, 1'b1, 1'b0);
        nextCycle();
        idle();
        sample();
        vecCount++;
        if (fwdB !== 2'b10) begin
            missCount++;
            $display("[TB] FAIL mem_beats_wb got b=%b want 10", fwdB);
        end
    endtask

    // lw x5 ; add x6,x5,x1 -> one stall, bubble, then data from WB
    task automatic test_load_use();
        doReset();
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
        sample();
        vecCount++;
        if (stall !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL lu_lw_stall got %b want 0", stall);
        end
        nextCycle();
        applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        sample();
        vecCount++;
        if (stall !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL lu_stall got %b want 1", stall);
        end
        nextCycle();
        sample();
        vecCount++;
        if (stall !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL lu_stall_once got %b want 0", stall);
        end
        // EX holds the bubble here, so nothing is forwarded
        vecCount++;
        if (fwdA !== 2'b00 || fwdB !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL lu_bubble got a=%b b=%b want 00/00", fwdA, fwdB);
        end
        nextCycle();
        idle();
        sample();
        // The load has moved on to WB by the time the add reaches EX
        vecCount++;
        if (fwdA !== 2'b01 || fwdB !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL lu_fwd got a=%b b=%b want a=01 b=00", fwdA, fwdB);
        end
    endtask

    // add x0,x1,x2 ; add x6,x0,x0 -> no forwarding from x0
    task automatic test_x0_filter();
        doReset();
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
        sample();
        vecCount++;
        if (stall !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL x0_stall got %b want 0", stall);
        end
        nextCycle();
        idle();
        sample();
        vecCount++;
        if (fwdA !== 2'b00 || fwdB !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL x0_fwd got a=%b b=%b want 00/00", fwdA, fwdB);
        end
        // Load to x0 must not stall either
        doReset();
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
        sample();
        vecCount++;
        if (stall !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL x0_load_stall got %b want 0", stall);
        end
    endtask

    // lw x5 in EX, dependent add in ID, branch taken -> flush wins
    task automatic test_flush();
        doReset();
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0);
        branchTaken = 1'b1;
        sample();
        vecCount++;
        if (flush !== 1'b1 || stall !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL flush_over_stall got flush=%b stall=%b want 1/0", flush, stall);
        end
        nextCycle();
        branchTaken = 1'b0;
        applyStimulus(1'b1, 5'd9, 5'd9, 5'd10, 1'b1, 1'b0);
        sample();
        vecCount++;
        if (flush !== 1'b0 || stall !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL flush_release got flush=%b stall=%b want 0/0", flush, stall);
        end
        nextCycle();
        idle();
        sample();
        // The squashed add x9 never entered EX, so x9 is not forwarded
        vecCount++;
        if (fwdA !== 2'b00 || fwdB !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL flush_bubble got a=%b b=%b want 00/00", fwdA, fwdB);
        end
    endtask

    // No-forwarding build: two stall cycles, constant selects, reset mid-stall
    task automatic test_no_forward();
        doReset();
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        sample();
        vecCount++;
        if (nfStall !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL nf_first_stall got %b want 0", nfStall);
        end
        nextCycle();
        applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            sample();
            vecCount++;
            if (nfStall !== 1'b1 || nfFwdA !== 2'b00) begin
                missCount++;
                $display("[TB] FAIL nf_stall_%0d got stall=%b a=%b want 1/00", i, nfStall, nfFwdA);
            end
            nextCycle();
        end
        sample();
        vecCount++;
        if (nfStall !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL nf_stall_end got %b want 0", nfStall);
        end
        nextCycle();
        idle();
        sample();
        vecCount++;
        if (nfFwdA !== 2'b00 || nfFwdB !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL nf_fwd got a=%b b=%b want 00/00", nfFwdA, nfFwdB);
        end

        // Reset pulse while stalled: outputs drop at once, tags are gone after
        nextCycle();
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        sample();
        vecCount++;
        if (nfStall !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL nf_pre_reset got %b want 1", nfStall);
        end
        rst = 1'b1;
        #1;
        vecCount++;
        if (nfStall !== 1'b0 || nfFlush !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL nf_reset_now got stall=%b flush=%b want 0/0", nfStall, nfFlush);
        end
        #1;
        rst = 1'b0;
        #1;
        vecCount++;
        if (nfStall !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL nf_after_reset got %b want 0", nfStall);
        end
        nextCycle();
        idle();
        sample();
        vecCount++;
        if (fwdA !== 2'b00 || nfFwdA !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL post_reset_fwd got a=%b nfA=%b want 00/00", fwdA, nfFwdA);
        end
    endtask

    initial begin
        rst = 1'b0;
        branchTaken = 1'b0;
        idle();
        test_reset();
        test_back_to_back();
        test_wb_and_priority();
        test_load_use();
        test_x0_filter();
        test_flush();
        test_no_forward();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    // Safety bound so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL timeout got running want finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
